// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle mini RISC-V core: opcodes, control FSM
// states, datapath select encodings and the per-state control word.
package riscv_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC_R   = 4'd6,
      EXEC_I   = 4'd7,
      ALU_WB   = 4'd8,
      BRANCH   = 4'd9,
      JUMP     = 4'd10,
      ILLEGAL  = 4'd11
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      SRC_A_PC     = 2'd0,
      SRC_A_RS1    = 2'd1,
      SRC_A_OLD_PC = 2'd2
   } src_a_e;

   typedef enum logic [1:0] {
      SRC_B_REG  = 2'd0,
      SRC_B_FOUR = 2'd1,
      SRC_B_IMM  = 2'd2
   } src_b_e;

   typedef enum logic [1:0] {
      WB_ALUOUT = 2'd0,
      WB_MDR    = 2'd1,
      WB_PC     = 2'd2
   } wb_sel_e;

   // State-only (Moore) part of the control word. Handshake-dependent terms
   // (fetch completion, store completion) are added outside this struct.
   typedef struct packed {
      logic    pc_write;
      logic    pc_write_cond;
      logic    pc_source;
      logic    i_or_d;
      logic    mem_read;
      logic    mem_write;
      logic    reg_write;
      wb_sel_e mem_to_reg;
      src_a_e  alu_src_a;
      src_b_e  alu_src_b;
      alu_op_e alu_op;
      logic    retire;
      logic    halted;
   } ctrl_t;

   // Control word presented while sitting in state s.
   function automatic ctrl_t moore_ctrl(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_a = SRC_A_PC;
            c.alu_src_b = SRC_B_FOUR;
            c.alu_op    = ALU_ADD;
         end
         DECODE: begin
            c.alu_src_a = SRC_A_OLD_PC;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_ADD;
         end
         MEM_ADDR: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_ADD;
         end
         MEM_RD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = WB_MDR;
            c.retire     = 1'b1;
         end
         MEM_WR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         EXEC_R: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_REG;
            c.alu_op    = ALU_FUNCT;
         end
         EXEC_I: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_FUNCT;
         end
         ALU_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = WB_ALUOUT;
            c.retire     = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a     = SRC_A_RS1;
            c.alu_src_b     = SRC_B_REG;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 1'b1;
            c.retire        = 1'b1;
         end
         JUMP: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = WB_PC;
            c.pc_write   = 1'b1;
            c.pc_source  = 1'b1;
            c.retire     = 1'b1;
         end
         ILLEGAL: c.halted = 1'b1;
         default: c.halted = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared multicycle mini RISC-V datapath. One phase per
// cycle; FETCH, MEM_RD and MEM_WR wait on mem_ready so memory latency may vary.
module multicycle_ctrl
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       pc_source,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] mem_to_reg,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       retire,
   output logic       halted,
   output logic [3:0] state
);

   state_e state_q;
   state_e state_d;
   ctrl_t  ctrl_q;
   logic   fetch_done;
   logic   store_done;

   // The branch outcome is applied by the datapath (pc_write_cond & zero), so
   // zero does not steer the sequence.
   logic   unused_zero;
   assign unused_zero = zero;

   // Next-state selection; opcode only matters in DECODE and MEM_ADDR.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         FETCH:    if (mem_ready) state_d = DECODE;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_R:         state_d = EXEC_R;
               OP_I:         state_d = EXEC_I;
               OP_BEQ:       state_d = BRANCH;
               OP_JAL:       state_d = JUMP;
               default:      state_d = ILLEGAL;
            endcase
         end
         MEM_ADDR: begin
            if (opcode == OP_LW)      state_d = MEM_RD;
            else if (opcode == OP_SW) state_d = MEM_WR;
            else                      state_d = ILLEGAL;
         end
         MEM_RD:   if (mem_ready) state_d = MEM_WB;
         MEM_WR:   if (mem_ready) state_d = FETCH;
         EXEC_R,
         EXEC_I:   state_d = ALU_WB;
         MEM_WB,
         ALU_WB,
         BRANCH,
         JUMP:     state_d = FETCH;
         ILLEGAL:  state_d = ILLEGAL;
         default:  state_d = ILLEGAL;
      endcase
   end

   // State register plus the registered Moore control word for the coming state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the control word resets to the FETCH pattern so memory is
         // requested in the very first cycle after release; the rst_n mask
         // below keeps every output at 0 while reset is held.
         state_q <= FETCH;
         ctrl_q  <= moore_ctrl(FETCH);
      end else begin
         // NOTE: non-blocking so state and control word update together from
         // the same pre-edge values.
         state_q <= state_d;
         ctrl_q  <= moore_ctrl(state_d);
      end
   end

   // Handshake completions that must act in the same cycle mem_ready arrives.
   assign fetch_done = (state_q == FETCH)  && mem_ready;
   assign store_done = (state_q == MEM_WR) && mem_ready;

   // Outputs: registered control word plus same-cycle handshake terms, all
   // forced low the moment rst_n falls so no partial write can escape.
   assign pc_write      = rst_n & (ctrl_q.pc_write | fetch_done);
   assign ir_write      = rst_n & fetch_done;
   assign retire        = rst_n & (ctrl_q.retire | store_done);
   assign pc_write_cond = rst_n & ctrl_q.pc_write_cond;
   assign pc_source     = rst_n & ctrl_q.pc_source;
   assign i_or_d        = rst_n & ctrl_q.i_or_d;
   assign mem_read      = rst_n & ctrl_q.mem_read;
   assign mem_write     = rst_n & ctrl_q.mem_write;
   assign reg_write     = rst_n & ctrl_q.reg_write;
   assign halted        = rst_n & ctrl_q.halted;
   assign mem_to_reg    = {2{rst_n}} & ctrl_q.mem_to_reg;
   assign alu_src_a     = {2{rst_n}} & ctrl_q.alu_src_a;
   assign alu_src_b     = {2{rst_n}} & ctrl_q.alu_src_b;
   assign alu_op        = {2{rst_n}} & ctrl_q.alu_op;
   assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector table for each
// instruction class, then hand-written reset sequences.
module tb_multicycle_ctrl;

   logic       clk;
   logic       rst_n;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, pc_source, i_or_d;
   logic       mem_read, mem_write, ir_write, reg_write;
   logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op;
   logic       retire, halted;
   logic [3:0] state;

   multicycle_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_source     (pc_source),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_write     (reg_write),
      .mem_to_reg    (mem_to_reg),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .retire        (retire),
      .halted        (halted),
      .state         (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Output bundle: pc_write pc_write_cond pc_source i_or_d mem_read mem_write
   // ir_write reg_write mem_to_reg[2] alu_src_a[2] alu_src_b[2] alu_op[2] retire halted
   logic [17:0] outs;
   assign outs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                  ir_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                  retire, halted};

   localparam logic [17:0] O_ZERO   = 18'b0_0_0_0_0_0_0_0_00_00_00_00_0_0;
   localparam logic [17:0] O_F_WAIT = 18'b0_0_0_0_1_0_0_0_00_00_01_00_0_0;
   localparam logic [17:0] O_F_RDY  = 18'b1_0_0_0_1_0_1_0_00_00_01_00_0_0;
   localparam logic [17:0] O_DEC    = 18'b0_0_0_0_0_0_0_0_00_10_10_00_0_0;
   localparam logic [17:0] O_MADDR  = 18'b0_0_0_0_0_0_0_0_00_01_10_00_0_0;
   localparam logic [17:0] O_MRD    = 18'b0_0_0_1_1_0_0_0_00_00_00_00_0_0;
   localparam logic [17:0] O_MWB    = 18'b0_0_0_0_0_0_0_1_01_00_00_00_1_0;
   localparam logic [17:0] O_MWR_W  = 18'b0_0_0_1_0_1_0_0_00_00_00_00_0_0;
   localparam logic [17:0] O_MWR_D  = 18'b0_0_0_1_0_1_0_0_00_00_00_00_1_0;
   localparam logic [17:0] O_XR     = 18'b0_0_0_0_0_0_0_0_00_01_00_10_0_0;
   localparam logic [17:0] O_XI     = 18'b0_0_0_0_0_0_0_0_00_01_10_10_0_0;
   localparam logic [17:0] O_AWB    = 18'b0_0_0_0_0_0_0_1_00_00_00_00_1_0;
   localparam logic [17:0] O_BR     = 18'b0_1_1_0_0_0_0_0_00_01_00_01_1_0;
   localparam logic [17:0] O_JMP    = 18'b1_0_1_0_0_0_0_1_10_00_00_00_1_0;
   localparam logic [17:0] O_ILL    = 18'b0_0_0_0_0_0_0_0_00_00_00_00_0_1;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BAD = 7'b1111111;

   typedef struct packed {
      logic [6:0]  op;
      logic        zero;
      logic        rdy;
      logic [3:0]  st;
      logic [17:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp;
   int   n_bad;
   int   n_retire;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [6:0] op, input logic z, input logic r,
                      input logic [3:0] st, input logic [17:0] exp);
      vec_t v;
      v.op = op; v.zero = z; v.rdy = r; v.st = st; v.exp = exp;
      vecs.push_back(v);
   endtask

   // Entered just after a falling edge: drive, settle, compare, advance one cycle.
   task automatic step(input vec_t v, input int idx);
      opcode    = v.op;
      zero      = v.zero;
      mem_ready = v.rdy;
      #1;
      check($sformatf("vec%0d state", idx), {28'd0, state}, {28'd0, v.st});
      check($sformatf("vec%0d outs", idx), {14'd0, outs}, {14'd0, v.exp});
      if (retire === 1'b1) n_retire++;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; n_retire = 0;
      rst_n = 1'b0; opcode = RT; zero = 1'b0; mem_ready = 1'b1;

      // R-type, zero-wait: 4 cycles
      add(RT, 0, 1, 4'd0, O_F_RDY); add(RT, 0, 1, 4'd1, O_DEC);
      add(RT, 0, 0, 4'd6, O_XR);    add(RT, 0, 1, 4'd8, O_AWB);
      // I-type, zero-wait: 4 cycles
      add(IT, 0, 1, 4'd0, O_F_RDY); add(IT, 0, 1, 4'd1, O_DEC);
      add(IT, 0, 1, 4'd7, O_XI);    add(IT, 0, 0, 4'd8, O_AWB);
      // LW, 2 fetch waits and 3 read waits: 10 cycles
      add(LW, 0, 0, 4'd0, O_F_WAIT); add(LW, 0, 0, 4'd0, O_F_WAIT);
      add(LW, 0, 1, 4'd0, O_F_RDY);  add(LW, 0, 1, 4'd1, O_DEC);
      add(LW, 0, 1, 4'd2, O_MADDR);  add(LW, 0, 0, 4'd3, O_MRD);
      add(LW, 0, 0, 4'd3, O_MRD);    add(LW, 0, 0, 4'd3, O_MRD);
      add(LW, 0, 1, 4'd3, O_MRD);    add(LW, 0, 1, 4'd4, O_MWB);
      // SW, zero-wait: 4 cycles
      add(SW, 0, 1, 4'd0, O_F_RDY); add(SW, 0, 1, 4'd1, O_DEC);
      add(SW, 0, 1, 4'd2, O_MADDR); add(SW, 0, 1, 4'd5, O_MWR_D);
      // SW, one write wait: 5 cycles
      add(SW, 0, 1, 4'd0, O_F_RDY); add(SW, 0, 1, 4'd1, O_DEC);
      add(SW, 0, 0, 4'd2, O_MADDR); add(SW, 0, 0, 4'd5, O_MWR_W);
      add(SW, 0, 1, 4'd5, O_MWR_D);
      // BEQ taken and not taken: 3 cycles each, same control pattern
      add(BEQ, 1, 1, 4'd0, O_F_RDY); add(BEQ, 1, 1, 4'd1, O_DEC); add(BEQ, 1, 1, 4'd9, O_BR);
      add(BEQ, 0, 1, 4'd0, O_F_RDY); add(BEQ, 0, 1, 4'd1, O_DEC); add(BEQ, 0, 1, 4'd9, O_BR);
      // JAL: 3 cycles
      add(JAL, 0, 1, 4'd0, O_F_RDY); add(JAL, 0, 1, 4'd1, O_DEC); add(JAL, 0, 1, 4'd10, O_JMP);
      // Illegal opcode: halts, ignores mem_ready toggling
      add(BAD, 0, 1, 4'd0, O_F_RDY); add(BAD, 0, 0, 4'd1, O_DEC);
      for (int i = 0; i < 22; i++) add(BAD, i[0], i[0], 4'd11, O_ILL);

      // Reset state, with mem_ready high to show nothing leaks through
      #1;
      check("reset state", {28'd0, state}, 32'd0);
      check("reset outs", {14'd0, outs}, {14'd0, O_ZERO});
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) step(vecs[i], i);
      check("retire count", n_retire, 32'd8);

      // Reset is the only exit from ILLEGAL
      rst_n = 1'b0;
      #1;
      check("ill rst state", {28'd0, state}, 32'd0);
      check("ill rst outs", {14'd0, outs}, {14'd0, O_ZERO});
      rst_n = 1'b1; mem_ready = 1'b0;
      #1;
      check("ill rel state", {28'd0, state}, 32'd0);
      check("ill rel outs", {14'd0, outs}, {14'd0, O_F_WAIT});
      @(posedge clk);
      @(negedge clk);

      // Asynchronous reset in the middle of a store wait
      begin
         vec_t v;
         v.op = SW; v.zero = 0; v.rdy = 1; v.st = 4'd0; v.exp = O_F_RDY; step(v, 100);
         v.st = 4'd1; v.exp = O_DEC;   step(v, 101);
         v.st = 4'd2; v.exp = O_MADDR; step(v, 102);
      end
      mem_ready = 1'b0;
      #1;
      check("mwr wait state", {28'd0, state}, 32'd5);
      check("mwr wait write", {31'd0, mem_write}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst mem_write", {31'd0, mem_write}, 32'd0);
      check("async rst state", {28'd0, state}, 32'd0);
      check("async rst outs", {14'd0, outs}, {14'd0, O_ZERO});
      @(negedge clk);
      check("held rst outs", {14'd0, outs}, {14'd0, O_ZERO});
      rst_n = 1'b1;
      #1;
      check("release state", {28'd0, state}, 32'd0);
      check("release outs", {14'd0, outs}, {14'd0, O_F_WAIT});
      @(posedge clk);
      @(negedge clk);
      #1;
      check("release+1 state", {28'd0, state}, 32'd0);
      check("release+1 outs", {14'd0, outs}, {14'd0, O_F_WAIT});
      mem_ready = 1'b1;
      #1;
      check("release fetch outs", {14'd0, outs}, {14'd0, O_F_RDY});
      @(posedge clk);
      @(negedge clk);
      #1;
      check("release decode", {28'd0, state}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences the shared multicycle mini RISC-V datapath: PC, instruction register, register file, single ALU, immediate generator and one unified memory port.
- Decodes the 7-bit opcode latched in the instruction register and drives datapath selects and write enables, one phase per cycle.
- Waits on a memory ready handshake, so memory latency may vary.
- Supported: LW, SW, BEQ, JAL, R-type, I-type ALU. Any other opcode halts the core.

Parameters:
- OP_LW, 7'b0000011, load opcode
- OP_SW, 7'b0100011, store opcode
- OP_BEQ, 7'b1100011, branch-equal opcode
- OP_JAL, 7'b1101111, jump-and-link opcode
- OP_R, 7'b0110011, R-type ALU opcode
- OP_I, 7'b0010011, I-type ALU opcode

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction-register bits [6:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC write
- pc_write_cond  out  1  PC write qualified by zero
- pc_source  out  1  0 = ALU result, 1 = ALUOut register
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  latch instruction register and old_pc
- reg_write  out  1  register-file write
- mem_to_reg  out  2  write-back data: 0 = ALUOut, 1 = MDR, 2 = PC
- alu_src_a  out  2  0 = PC, 1 = rs1 reg A, 2 = old_pc
- alu_src_b  out  2  0 = reg B, 1 = constant 4, 2 = imm
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- retire  out  1  one-cycle pulse on the last cycle of each instruction
- halted  out  1  illegal opcode seen; core stopped
- state  out  4  current state, for debug

Behaviour:
- Reset: rst_n low asynchronously forces state FETCH. All enables 0, all selects 0, retire 0, halted 0.
- Reset mid-instruction abandons the instruction. No partial writes occur after rst_n falls.
- Default: every output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=00.
  - Stay in FETCH while mem_ready=0.
  - When mem_ready=1 (Mealy, same cycle): ir_write=1, pc_write=1, pc_source=0, then go to DECODE.
  - Effect: PC is written only once per fetch, regardless of wait cycles.
- DECODE:
  - Outputs: alu_src_a=2, alu_src_b=2, alu_op=00. ALUOut gets branch/jump target old_pc+imm.
  - Next state: LW/SW go to MEM_ADDR, R goes to EXEC_R, I goes to EXEC_I, BEQ goes to BRANCH, JAL goes to JUMP, anything else goes to ILLEGAL.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=2, alu_op=00.
  - Next state: LW goes to MEM_RD, SW goes to MEM_WR.
- MEM_RD:
  - Outputs: mem_read=1, i_or_d=1.
  - Hold while mem_ready=0, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, retire=1, then go to FETCH.
- MEM_WR:
  - Outputs: mem_write=1, i_or_d=1.
  - Hold while mem_ready=0.
  - On mem_ready=1: retire=1, go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=10, then go to ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=10, then go to ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, retire=1, then go to FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=01, pc_write_cond=1, pc_source=1, retire=1.
  - Next state: FETCH.
- JUMP:
  - Outputs: reg_write=1, mem_to_reg=2, pc_write=1, pc_source=1, retire=1.
  - rd receives the already-incremented PC (old_pc+4).
  - Next state: FETCH.
- ILLEGAL: halted=1, all enables 0. Terminal; only reset exits.
- mem_read and mem_write are never both 1.
- Request signals stay asserted and stable until mem_ready.
- mem_ready outside a memory state is ignored.
- Latency with zero-wait memory (mem_ready tied 1): LW 5, SW 4, R/I 4, BEQ 3, JAL 3 cycles.
  - Each wait cycle in FETCH, MEM_RD or MEM_WR adds 1.
- opcode is sampled only in DECODE and MEM_ADDR; it is stable after ir_write.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants;
  - state enum (FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP, ILLEGAL);
  - alu_op, alu_src_a/b, mem_to_reg encodings.
- The immediate generator and the ALU decoder reuse these encodings.
- No sub-module: one state register plus next-state and output logic.

Test Plan:
- mem_ready=1, opcode=OP_R:
  - states go FETCH, DECODE, EXEC_R, ALU_WB, FETCH;
  - reg_write=1 only in cycle 4; retire pulses once per 4 cycles.
- OP_LW, mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD:
  - total 10 cycles;
  - pc_write and ir_write each high exactly 1 cycle;
  - mem_read held stable throughout each wait.
- OP_BEQ with zero=1, then zero=0:
  - BRANCH shows pc_write_cond=1, pc_source=1 in both cases;
  - 3 cycles each; retire asserted in BRANCH.
- OP_JAL: JUMP asserts reg_write=1, mem_to_reg=2, pc_write=1, pc_source=1 simultaneously.
- opcode=7'b1111111: ILLEGAL reached after DECODE; halted=1 and all enables 0 for 20+ cycles, including while mem_ready toggles.
- rst_n low asynchronously mid-MEM_WR:
  - outputs clear before the next clk edge; mem_write=0 immediately;
  - after release, first state is FETCH with mem_read=1.
